// File: rtl/wb_pkg.sv
// Shared constants and types for the dual-lane writeback commit unit.
package wb_pkg;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

  // Which execution lane supplies the oldest valid result of the cycle.
  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_LANE0 = 2'd1,
    SEL_LANE1 = 2'd2
  } lane_sel_e;

endpackage

// File: rtl/wb_ring.sv
// Dual-push / dual-pop circular buffer of pending writeback results.
module wb_ring #(
  parameter int unsigned DEPTH = wb_pkg::DEPTH,
  parameter int unsigned AW    = wb_pkg::AW,
  parameter int unsigned DW    = wb_pkg::DW
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic [1:0]                    npush,
  input  logic [AW-1:0]                 prd0,
  input  logic [DW-1:0]                 pd0,
  input  logic [AW-1:0]                 prd1,
  input  logic [DW-1:0]                 pd1,
  input  logic [1:0]                    npop,
  output logic [AW-1:0]                 hrd0,
  output logic [DW-1:0]                 hd0,
  output logic [AW-1:0]                 hrd1,
  output logic [DW-1:0]                 hd1,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0]              valid,
  output logic [DEPTH-1:0][AW-1:0]      rds
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]              head;
  logic [PW-1:0]              tail;
  logic [PW-1:0]              head1;
  logic [PW-1:0]              tail1;
  logic [PW-1:0]              off;
  logic [DEPTH-1:0][AW-1:0]   mrd;
  logic [DEPTH-1:0][DW-1:0]   mdata;

  assign head1 = head + PW'(1);
  assign tail1 = tail + PW'(1);

  assign hrd0 = mrd[head];
  assign hd0  = mdata[head];
  assign hrd1 = mrd[head1];
  assign hd1  = mdata[head1];
  assign rds  = mrd;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(npop);
      tail  <= tail + PW'(npush);
      count <= count + CW'(npush) - CW'(npop);
    end
  end

  always_ff @(posedge clk) begin
    if (npush != 2'd0) begin
      mrd[tail]   <= prd0;
      mdata[tail] <= pd0;
    end
    if (npush == 2'd2) begin
      mrd[tail1]   <= prd1;
      mdata[tail1] <= pd1;
    end
  end

  always_comb begin
    valid = '0;
    off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - head;
      valid[i] = (CW'(off) < count);
    end
  end

endmodule

// File: rtl/wb_commit2.sv
// Dual-lane writeback commit unit driving the x (older) / y (younger) register-file write ports.
// Optional macro WB_BYPASS_EN: results accepted into an idle unit load the ports directly.
module wb_commit2 #(
  parameter int unsigned DEPTH = wb_pkg::DEPTH,
  parameter int unsigned AW    = wb_pkg::AW,
  parameter int unsigned DW    = wb_pkg::DW
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 v0,
  input  logic [AW-1:0]        rd0,
  input  logic [DW-1:0]        d0,
  input  logic                 v1,
  input  logic [AW-1:0]        rd1,
  input  logic [DW-1:0]        d1,
  output logic                 in_ready,
  input  logic                 hold,
  output logic                 wex,
  output logic [AW-1:0]        wnx,
  output logic [DW-1:0]        dx,
  output logic                 wey,
  output logic [AW-1:0]        wny,
  output logic [DW-1:0]        dy,
  output logic [(1<<AW)-1:0]   pend,
  output logic                 empty
);

  import wb_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]              count;
  logic [DEPTH-1:0]           valid;
  logic [DEPTH-1:0][AW-1:0]   rds;
  logic [AW-1:0]              hrd0;
  logic [DW-1:0]              hd0;
  logic [AW-1:0]              hrd1;
  logic [DW-1:0]              hd1;
  logic [1:0]                 npush;
  logic [1:0]                 npop;
  logic                       byp;
  logic                       both;
  lane_sel_e                  first_sel;
  logic [AW-1:0]              frd;
  logic [DW-1:0]              fd;

  assign in_ready = clrn & (count <= CW'(DEPTH - 2));
  assign both     = v0 & v1;

`ifdef WB_BYPASS_EN
  assign byp = clrn & ~hold & (count == '0);
`else
  assign byp = 1'b0;
`endif

  // The oldest valid lane always takes the first ring slot (or the x port on bypass).
  always_comb begin
    first_sel = SEL_NONE;
    if (v0)
      first_sel = SEL_LANE0;
    else if (v1)
      first_sel = SEL_LANE1;
  end

  assign frd = (first_sel == SEL_LANE1) ? rd1 : rd0;
  assign fd  = (first_sel == SEL_LANE1) ? d1  : d0;

  always_comb begin
    npush = 2'd0;
    if (in_ready && !byp && first_sel != SEL_NONE)
      npush = both ? 2'd2 : 2'd1;
  end

  always_comb begin
    npop = 2'd0;
    if (clrn && !hold) begin
      if (count >= CW'(2))
        npop = 2'd2;
      else
        npop = count[1:0];
    end
  end

  wb_ring #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ring (
    .clk   (clk),
    .clrn  (clrn),
    .npush (npush),
    .prd0  (frd),
    .pd0   (fd),
    .prd1  (rd1),
    .pd1   (d1),
    .npop  (npop),
    .hrd0  (hrd0),
    .hd0   (hd0),
    .hrd1  (hrd1),
    .hd1   (hd1),
    .count (count),
    .valid (valid),
    .rds   (rds)
  );

  // Unused ports keep their number/data; only the enable drops.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wex <= 1'b0;
      wey <= 1'b0;
      wnx <= '0;
      wny <= '0;
      dx  <= '0;
      dy  <= '0;
    end else if (byp) begin
      wex <= (first_sel != SEL_NONE) & (frd != '0);
      if (first_sel != SEL_NONE) begin
        wnx <= frd;
        dx  <= fd;
      end
      wey <= both & (rd1 != '0);
      if (both) begin
        wny <= rd1;
        dy  <= d1;
      end
    end else if (hold) begin
      wex <= 1'b0;
      wey <= 1'b0;
    end else begin
      wex <= (npop != 2'd0) & (hrd0 != '0);
      if (npop != 2'd0) begin
        wnx <= hrd0;
        dx  <= hd0;
      end
      wey <= (npop == 2'd2) & (hrd1 != '0);
      if (npop == 2'd2) begin
        wny <= hrd1;
        dy  <= hd1;
      end
    end
  end

  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i])
        pend[rds[i]] = 1'b1;
    end
    if (wex)
      pend[wnx] = 1'b1;
    if (wey)
      pend[wny] = 1'b1;
    pend[0] = 1'b0;
  end

  assign empty = (count == '0) & ~wex & ~wey;

endmodule
